// File: rtl/vc_queue_pkg.sv
// ============================================================================
// Module   : vc_queue_pkg
// Brief    : Shared types and the round-robin pick helper for vc_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vc_queue_pkg;

    localparam int C_MAX_VC = 32;
    localparam int C_IDX_W  = 5;

    typedef struct packed {
        logic               valid;
        logic [C_IDX_W-1:0] idx;
    } rr_grant_t;

    // Offsets are scanned from the farthest to the nearest so the requester
    // closest after last_grant is the one left in the result.
    function automatic rr_grant_t rr_pick(
        input logic [C_MAX_VC-1:0] req,
        input int                  num_vc,
        input int                  last_grant
    );
        rr_grant_t res;
        int        cand;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int k = C_MAX_VC; k >= 1; k--) begin
            if (k <= num_vc) begin
                cand = last_grant + k;
                if (cand >= num_vc) begin
                    cand = cand - num_vc;
                end
                if (req[cand[C_IDX_W-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = C_IDX_W'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vc_fifo.sv
// ============================================================================
// Module   : vc_fifo
// Brief    : Single-channel circular buffer with registered full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic [C_CNT_W-1:0] w_count_nxt;
    logic               r_full;
    logic               r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !i_pop) begin
            w_count_nxt = r_count + C_CNT_W'(1);
        end else if (!i_push && i_pop) begin
            w_count_nxt = r_count - C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + C_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + C_PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/vc_queue.sv
// ============================================================================
// Module   : vc_queue
// Brief    : Multi-VC AXI-Stream buffer, per-VC FIFOs drained round-robin.
// Options  : VC_QUEUE_PACKET_LOCK_EN - hold the grant until a TLAST beat loads
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int BUFFER_LENGTH = 4,
    parameter int NUM_VC        = 2,
    parameter int VC_W          = $clog2(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [VC_W-1:0]       s_tid,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [VC_W-1:0]       m_tid,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic [NUM_VC-1:0]     m_vc_ready,
    output logic [NUM_VC-1:0]     vc_full,
    output logic [NUM_VC-1:0]     vc_empty
);

    import vc_queue_pkg::*;

    logic [NUM_VC-1:0]   w_push;
    logic [NUM_VC-1:0]   w_pop;
    logic [NUM_VC-1:0]   w_req;
    logic [C_MAX_VC-1:0] w_req_ext;
    logic [DATA_WIDTH:0] w_head [NUM_VC];
    logic [DATA_WIDTH:0] w_sel_head;
    rr_grant_t           w_pick;
    logic [VC_W-1:0]     w_grant;
    logic [VC_W-1:0]     r_last_grant;
    logic                w_load;
    logic                w_tid_hit;
    logic                w_sel_full;

    // An out-of-range TID matches no VC, so it is never ready.
    always_comb begin
        w_tid_hit  = 1'b0;
        w_sel_full = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (s_tid == VC_W'(v)) begin
                w_tid_hit  = 1'b1;
                w_sel_full = vc_full[v];
            end
        end
    end

    assign s_tready = w_tid_hit && !w_sel_full;

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            assign w_push[v] = s_tvalid && s_tready && (s_tid == VC_W'(v));
            assign w_pop[v]  = w_load && (w_grant == VC_W'(v));

            vc_fifo #(
                .WIDTH (DATA_WIDTH + 1),
                .DEPTH (BUFFER_LENGTH)
            ) u_fifo (
                .clk         (clk),
                .rst         (rst),
                .i_push      (w_push[v]),
                .i_push_data ({s_tlast, s_tdata}),
                .i_pop       (w_pop[v]),
                .o_head      (w_head[v]),
                .o_full      (vc_full[v]),
                .o_empty     (vc_empty[v])
            );
        end
    endgenerate

`ifdef VC_QUEUE_PACKET_LOCK_EN
    logic r_locked;
`endif

    always_comb begin
        w_req = ~vc_empty & m_vc_ready;
`ifdef VC_QUEUE_PACKET_LOCK_EN
        if (r_locked) begin
            w_req = w_req & (NUM_VC'(1) << r_last_grant);
        end
`endif
        w_req_ext              = '0;
        w_req_ext[NUM_VC-1:0]  = w_req;
    end

    assign w_pick  = rr_pick(w_req_ext, NUM_VC, int'(r_last_grant));
    assign w_grant = w_pick.idx[VC_W-1:0];
    assign w_load  = (!m_tvalid || m_tready) && w_pick.valid;

    always_comb begin
        w_sel_head = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_grant == VC_W'(v)) begin
                w_sel_head = w_head[v];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata      <= '0;
            m_tid        <= '0;
            m_tlast      <= 1'b0;
            m_tvalid     <= 1'b0;
            r_last_grant <= VC_W'(NUM_VC - 1);
        end else if (w_load) begin
            m_tdata      <= w_sel_head[DATA_WIDTH-1:0];
            m_tlast      <= w_sel_head[DATA_WIDTH];
            m_tid        <= w_grant;
            m_tvalid     <= 1'b1;
            r_last_grant <= w_grant;
        end else if (m_tready) begin
            m_tvalid     <= 1'b0;
        end
    end

`ifdef VC_QUEUE_PACKET_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (w_load) begin
            r_locked <= !w_sel_head[DATA_WIDTH];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_queue.sv
// ============================================================================
// Module   : tb_vc_queue
// Brief    : Scoreboard bench for vc_queue against a queue-level reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NV    = 2;
    localparam int VW    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [VW-1:0] s_tid = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [VW-1:0] m_tid;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [NV-1:0] m_vc_ready = '0;
    logic [NV-1:0] vc_full;
    logic [NV-1:0] vc_empty;

    vc_queue #(
        .DATA_WIDTH    (DW),
        .BUFFER_LENGTH (DEPTH),
        .NUM_VC        (NV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tid      (s_tid),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tid      (m_tid),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_vc_ready (m_vc_ready),
        .vc_full    (vc_full),
        .vc_empty   (vc_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [VW-1:0] t;
    } beat_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    beat_t         mq [NV][$];
    beat_t         exp_q [$];
    logic [DW-1:0] out_log [$];
    bit            mv;
    beat_t         mout;
    int            lg;
    bit            locked;
    logic          last_sready;
    int            valid_cnt;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mq[v].delete();
        exp_q.delete();
        mv     = 1'b0;
        mout.d = '0;
        mout.l = 1'b0;
        mout.t = '0;
        lg     = NV - 1;
        locked = 1'b0;
    endtask

    // One clock of the queue-level model: decide the output load from the
    // occupancy seen before the edge, then take the input beat.
    task automatic model_step(input logic v, input logic [VW-1:0] tid, input logic [DW-1:0] d,
                              input logic l, input logic mr, input logic [NV-1:0] vr);
        int    sz [NV];
        bit    acc;
        bit    found;
        int    g;
        beat_t b;
        for (int c = 0; c < NV; c++) sz[c] = mq[c].size();
        acc   = v && (int'(tid) < NV) && (sz[tid] < DEPTH);
        found = 1'b0;
        g     = 0;
        if (!mv || mr) begin
            for (int k = 1; k <= NV; k++) begin
                int c;
                c = (lg + k) % NV;
                if (!found && sz[c] > 0 && vr[c] && (!locked || c == lg)) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            if (found) begin
                mout = mq[g].pop_front();
                exp_q.push_back(mout);
                mv = 1'b1;
                lg = g;
`ifdef VC_QUEUE_PACKET_LOCK_EN
                locked = !mout.l;
`endif
            end else if (mr) begin
                mv = 1'b0;
            end
        end
        if (acc) begin
            b.d = d;
            b.l = l;
            b.t = tid;
            mq[tid].push_back(b);
        end
    endtask

    task automatic step(input logic v, input logic [VW-1:0] tid, input logic [DW-1:0] d,
                        input logic l, input logic mr, input logic [NV-1:0] vr);
        logic [NV-1:0] ef;
        logic [NV-1:0] ee;
        @(negedge clk);
        s_tvalid   = v;
        s_tid      = tid;
        s_tdata    = d;
        s_tlast    = l;
        m_tready   = mr;
        m_vc_ready = vr;
        #1;
        last_sready = s_tready;
        if (rst) begin
            model_reset();
        end else begin
            chk("s_tready", s_tready, (int'(tid) < NV) && (mq[tid].size() < DEPTH));
            model_step(v, tid, d, l, mr, vr);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NV; c++) begin
            ef[c] = (mq[c].size() == DEPTH);
            ee[c] = (mq[c].size() == 0);
        end
        chk("m_tvalid", m_tvalid, mv);
        chk("vc_full", vc_full, ef);
        chk("vc_empty", vc_empty, ee);
        if (mv) begin
            chk("m_tdata_hold", m_tdata, mout.d);
            chk("m_tid_hold", m_tid, mout.t);
            chk("m_tlast_hold", m_tlast, mout.l);
        end
    endtask

    task automatic idle(input int n, input logic mr, input logic [NV-1:0] vr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, mr, vr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, '0, 32'hDEAD_0000, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 2'b11);
        rst = 1'b0;
        out_log.delete();
    endtask

    task automatic chk_log(input string name, input logic [DW-1:0] e [$]);
        chk(name, out_log.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < out_log.size()) chk(name, out_log[i], e[i]);
        end
    endtask

    // Scoreboard monitor: every accepted output beat must be the next prediction.
    always begin
        beat_t e;
        @(negedge clk);
        #2;
        if (!rst && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_tdata, 0);
                if (m_tdata == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0 with no beat expected");
                end
            end else begin
                e = exp_q.pop_front();
                chk("sb_tdata", m_tdata, e.d);
                chk("sb_tid", m_tid, e.t);
                chk("sb_tlast", m_tlast, e.l);
            end
            out_log.push_back(m_tdata);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] eq [$];
        int            acc;
        model_reset();
        do_reset();

        // Fill VC0 with output stalled: 4 in the FIFO, 1 in the output register.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'hA0 + i, 1'b1, 1'b0, 2'b11);
            if (last_sready) acc++;
        end
        chk("fill_accepts", acc, 5);
        chk("fill_full0", vc_full[0], 1);
        idle(8, 1'b1, 2'b11);
        eq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        chk_log("fill_order", eq);

        // Round robin across two VCs.
        do_reset();
        step(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b1, 32'h21, 1'b1, 1'b0, 2'b11);
        idle(6, 1'b1, 2'b11);
        eq = '{32'h10, 32'h20, 32'h11, 32'h21};
        chk_log("rr_order", eq);

        // Per-VC backpressure: VC0 blocked, VC1 drains.
        do_reset();
        step(1'b1, 1'b0, 32'h30, 1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b0, 32'h31, 1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b1, 32'h41, 1'b1, 1'b1, 2'b10);
        idle(4, 1'b1, 2'b10);
        chk("bp_vc0_held", vc_empty[0], 0);
        eq = '{32'h40, 32'h41};
        chk_log("bp_vc1_only", eq);
        out_log.delete();
        idle(5, 1'b1, 2'b11);
        eq = '{32'h30, 32'h31};
        chk_log("bp_vc0_release", eq);

        // Full-rate stream through VC1 exercising pointer wrap.
        do_reset();
        valid_cnt = 0;
        eq.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 32'h100 + i, 1'b1, 1'b1, 2'b11);
            eq.push_back(32'h100 + i);
            if (m_tvalid) valid_cnt++;
            chk("stream_not_full", vc_full[1], 0);
        end
        chk("stream_gapless", valid_cnt, 19);
        idle(3, 1'b1, 2'b11);
        chk_log("stream_order", eq);

        // Packet interleave behaviour.
        do_reset();
        step(1'b1, 1'b0, 32'h1, 1'b0, 1'b1, 2'b11);
        step(1'b1, 1'b1, 32'h7, 1'b1, 1'b1, 2'b11);
        step(1'b1, 1'b0, 32'h2, 1'b0, 1'b1, 2'b11);
        step(1'b1, 1'b0, 32'h3, 1'b1, 1'b1, 2'b11);
        idle(6, 1'b1, 2'b11);
`ifdef VC_QUEUE_PACKET_LOCK_EN
        eq = '{32'h1, 32'h2, 32'h3, 32'h7};
`else
        eq = '{32'h1, 32'h7, 32'h2, 32'h3};
`endif
        chk_log("pkt_order", eq);

        // Random traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                chk("post_reset_empty", vc_empty, 2'b11);
            end
            step(1'($urandom_range(0, 1)), VW'($urandom_range(0, NV - 1)), DW'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                 NV'($urandom_range(0, (1 << NV) - 1)));
        end

        // Drain; close any open packet so a lock cannot strand other VCs.
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !mv && mq[0].size() == 0 && mq[1].size() == 0) break;
            step(locked, VW'(lg), 32'hC0DE, 1'b1, 1'b1, 2'b11);
        end
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_valid", m_tvalid, 0);
        chk("drain_empty", vc_empty, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
